// File: rtl/pipe_pkg.sv
// Shared constants, state encoding and MEM->WB payload layout for the elastic pipe stage.
package pipe_pkg;

  localparam int unsigned LANES_D = 16;
  localparam int unsigned DW_D    = 32;
  localparam int unsigned RAW_D   = 4;
  localparam int unsigned ACW_D   = 3;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_st_t;

  typedef struct packed {
    logic [LANES_D*DW_D-1:0] alu_out;
    logic [LANES_D*DW_D-1:0] read_data;
    logic [ACW_D-1:0]        alu_control;
    logic                    pc_src;
    logic                    reg_write;
    logic                    mem_to_reg;
    logic [RAW_D-1:0]        wa3;
    logic                    v_s;
    logic [LANES_D-1:0]      lane_mask;
  } mw_payload_t;

  // Fields that a flush must clear so a killed beat can never cause a write.
  function automatic mw_payload_t flush_clr_mask();
    mw_payload_t m;
    m            = '0;
    m.pc_src     = 1'b1;
    m.reg_write  = 1'b1;
    m.mem_to_reg = 1'b1;
    m.lane_mask  = '1;
    return m;
  endfunction

endpackage

// File: rtl/pipe_skid_buf.sv
// Generic valid/ready register stage; two-entry skid buffer when PIPE_MW_SKID_EN is
// defined, otherwise a single entry with a combinational ready path.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned    W         = 8,
  parameter logic [W-1:0]   FLUSH_CLR = '0
) (
  input  logic         CLK,
  input  logic         RST_N,
  input  logic         FLUSH,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic [W-1:0] main_q;
  logic         accept;
  logic         retire;

  assign accept   = in_valid && in_ready;
  assign retire   = out_valid && out_ready;
  assign out_data = main_q;

`ifdef PIPE_MW_SKID_EN
  pipe_st_t     st_q;
  logic [W-1:0] skid_q;

  // Ready is decoded from state flops only, so out_ready never reaches in_ready.
  assign in_ready  = (st_q != SKID);
  assign out_valid = (st_q != EMPTY);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      st_q   <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
    end else if (FLUSH) begin
      st_q   <= EMPTY;
      main_q <= main_q & ~FLUSH_CLR;
      skid_q <= '0;
    end else begin
      unique case (st_q)
        EMPTY: begin
          if (accept) begin
            main_q <= in_data;
            st_q   <= FULL;
          end
        end
        FULL: begin
          if (accept && retire) begin
            main_q <= in_data;
          end else if (accept) begin
            skid_q <= in_data;
            st_q   <= SKID;
          end else if (retire) begin
            st_q   <= EMPTY;
          end
        end
        SKID: begin
          if (retire) begin
            main_q <= skid_q;
            skid_q <= '0;
            st_q   <= FULL;
          end
        end
        default: st_q <= EMPTY;
      endcase
    end
  end
`else
  logic valid_q;

  assign in_ready  = !valid_q || out_ready;
  assign out_valid = valid_q;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else if (FLUSH) begin
      valid_q <= 1'b0;
      main_q  <= main_q & ~FLUSH_CLR;
    end else if (accept) begin
      valid_q <= 1'b1;
      main_q  <= in_data;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end
`endif

endmodule

// File: rtl/pipe_reg_mw_elastic.sv
// Elastic MEM->WB pipeline stage with flush and per-lane write mask.
// Optional skid buffer enabled by defining PIPE_MW_SKID_EN; parameters must match pipe_pkg defaults.
module pipe_reg_mw_elastic
  import pipe_pkg::*;
#(
  parameter int unsigned LANES = LANES_D,
  parameter int unsigned DW    = DW_D,
  parameter int unsigned RAW   = RAW_D,
  parameter int unsigned ACW   = ACW_D
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                FLUSH,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [LANES*DW-1:0] ALUOutM,
  input  logic [LANES*DW-1:0] ReadDataM,
  input  logic [ACW-1:0]      ALUControlM,
  input  logic                PCSrcM,
  input  logic                RegWriteM,
  input  logic                MemtoRegM,
  input  logic                v_s_m,
  input  logic [RAW-1:0]      WA3M,
  input  logic [LANES-1:0]    LaneMaskM,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [LANES*DW-1:0] ALUOutW,
  output logic [LANES*DW-1:0] ReadDataW,
  output logic [ACW-1:0]      ALUControlW,
  output logic                PCSrcW,
  output logic                RegWriteW,
  output logic                MemtoRegW,
  output logic [RAW-1:0]      WA3W,
  output logic                v_s_w,
  output logic [LANES-1:0]    LaneMaskW
);

  localparam int unsigned PW = $bits(mw_payload_t);

  mw_payload_t   in_p;
  mw_payload_t   out_p;
  logic [PW-1:0] out_flat;

  always_comb begin
    in_p             = '0;
    in_p.alu_out     = ALUOutM;
    in_p.read_data   = ReadDataM;
    in_p.alu_control = ALUControlM;
    in_p.pc_src      = PCSrcM;
    in_p.reg_write   = RegWriteM;
    in_p.mem_to_reg  = MemtoRegM;
    in_p.wa3         = WA3M;
    in_p.v_s         = v_s_m;
    // Scalar beats may only write lane 0.
    in_p.lane_mask   = v_s_m ? LaneMaskM : (LaneMaskM & LANES'(1));
  end

  pipe_skid_buf #(
    .W         (PW),
    .FLUSH_CLR (flush_clr_mask())
  ) u_buf (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .FLUSH     (FLUSH),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_flat)
  );

  assign out_p       = mw_payload_t'(out_flat);
  assign ALUOutW     = out_p.alu_out;
  assign ReadDataW   = out_p.read_data;
  assign ALUControlW = out_p.alu_control;
  assign PCSrcW      = out_p.pc_src;
  assign RegWriteW   = out_p.reg_write;
  assign MemtoRegW   = out_p.mem_to_reg;
  assign WA3W        = out_p.wa3;
  assign v_s_w       = out_p.v_s;
  assign LaneMaskW   = out_p.lane_mask;

endmodule

// File: tb/tb_pipe_reg_mw_elastic.sv
// Self-checking bench for pipe_reg_mw_elastic: queue-based reference model plus directed literal checks.
module tb_pipe_reg_mw_elastic;

  localparam int LANES = 16;
  localparam int DW    = 32;
  localparam int RAW   = 4;
  localparam int ACW   = 3;
`ifdef PIPE_MW_SKID_EN
  localparam bit HAS_SKID = 1'b1;
`else
  localparam bit HAS_SKID = 1'b0;
`endif

  typedef struct packed {
    logic [LANES*DW-1:0] alu;
    logic [LANES*DW-1:0] rd;
    logic [ACW-1:0]      ctl;
    logic                pcs;
    logic                rw;
    logic                m2r;
    logic [RAW-1:0]      wa;
    logic                vs;
    logic [LANES-1:0]    mask;
  } beat_t;
  localparam int BW = $bits(beat_t);

  logic                CLK = 1'b0;
  logic                RST_N = 1'b0;
  logic                FLUSH = 1'b0;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [LANES*DW-1:0] ALUOutM = '0, ReadDataM = '0;
  logic [ACW-1:0]      ALUControlM = '0;
  logic                PCSrcM = 1'b0, RegWriteM = 1'b0, MemtoRegM = 1'b0, v_s_m = 1'b0;
  logic [RAW-1:0]      WA3M = '0;
  logic [LANES-1:0]    LaneMaskM = '0;
  logic                out_valid;
  logic                out_ready = 1'b0;
  logic [LANES*DW-1:0] ALUOutW, ReadDataW;
  logic [ACW-1:0]      ALUControlW;
  logic                PCSrcW, RegWriteW, MemtoRegW, v_s_w;
  logic [RAW-1:0]      WA3W;
  logic [LANES-1:0]    LaneMaskW;

  pipe_reg_mw_elastic #(.LANES(LANES), .DW(DW), .RAW(RAW), .ACW(ACW)) dut (
    .CLK(CLK), .RST_N(RST_N), .FLUSH(FLUSH),
    .in_valid(in_valid), .in_ready(in_ready),
    .ALUOutM(ALUOutM), .ReadDataM(ReadDataM), .ALUControlM(ALUControlM),
    .PCSrcM(PCSrcM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM), .v_s_m(v_s_m),
    .WA3M(WA3M), .LaneMaskM(LaneMaskM),
    .out_valid(out_valid), .out_ready(out_ready),
    .ALUOutW(ALUOutW), .ReadDataW(ReadDataW), .ALUControlW(ALUControlW),
    .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW),
    .WA3W(WA3W), .v_s_w(v_s_w), .LaneMaskW(LaneMaskW)
  );

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: the stage is a FIFO of capacity 2 (skid) or 1 (no skid).
  beat_t q[$];
  bit    flushed_now = 1'b0;

  function automatic bit model_rdy();
    if (HAS_SKID) return q.size() < 2;
    return (q.size() == 0) || out_ready;
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      q.delete();
      flushed_now = 1'b0;
    end else begin
      bit    acc;
      bit    ret;
      beat_t b;
      acc = in_valid && model_rdy();
      ret = (q.size() != 0) && out_ready;
      flushed_now = FLUSH;
      if (FLUSH) begin
        q.delete();
      end else begin
        if (ret) void'(q.pop_front());
        if (acc) begin
          b = '{alu: ALUOutM, rd: ReadDataM, ctl: ALUControlM, pcs: PCSrcM, rw: RegWriteM,
                m2r: MemtoRegM, wa: WA3M, vs: v_s_m,
                mask: v_s_m ? LaneMaskM : {{(LANES-1){1'b0}}, LaneMaskM[0]}};
          q.push_back(b);
        end
      end
    end
  end

  // Per-cycle compare against the model.
  always @(negedge CLK) begin
    if (RST_N) begin
      chk("in_ready", BW'(in_ready), BW'(model_rdy()));
      chk("out_valid", BW'(out_valid), BW'(q.size() != 0));
      if (q.size() != 0) begin
        chk("payload", {ALUOutW, ReadDataW, ALUControlW, PCSrcW, RegWriteW, MemtoRegW,
                        WA3W, v_s_w, LaneMaskW}, q[0]);
      end else if (flushed_now) begin
        chk("flush_ctrl", BW'({PCSrcW, RegWriteW, MemtoRegW, LaneMaskW}), '0);
      end
    end
  end

  // Record retired beats for the directed literal checks.
  logic [RAW-1:0]   seen_wa[$];
  logic [LANES-1:0] mask_by_wa [16];
  always @(negedge CLK) begin
    if (RST_N && out_valid && out_ready) begin
      seen_wa.push_back(WA3W);
      mask_by_wa[WA3W] = LaneMaskW;
    end
  end

  int omode = 0;  // 0: always ready, 1: random, 2: stalled
  always @(posedge CLK) begin
    #1;
    case (omode)
      0:       out_ready = 1'b1;
      1:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b0;
    endcase
  end

  function automatic beat_t rand_beat(input logic [RAW-1:0] wa, input logic vs,
                                      input logic [LANES-1:0] mask);
    beat_t b;
    for (int i = 0; i < LANES; i++) begin
      b.alu[i*DW +: DW] = $urandom;
      b.rd[i*DW +: DW]  = $urandom;
    end
    b.ctl  = ACW'($urandom);
    b.pcs  = 1'($urandom);
    b.rw   = 1'($urandom);
    b.m2r  = 1'($urandom);
    b.wa   = wa;
    b.vs   = vs;
    b.mask = mask;
    return b;
  endfunction

  // Called at #1 after a rising edge; returns at #1 after the accepting edge.
  task automatic send(input beat_t b);
    int unsigned t;
    bit rdy;
    t = 0;
    in_valid = 1'b1;
    ALUOutM = b.alu; ReadDataM = b.rd; ALUControlM = b.ctl; PCSrcM = b.pcs;
    RegWriteM = b.rw; MemtoRegM = b.m2r; WA3M = b.wa; v_s_m = b.vs; LaneMaskM = b.mask;
    forever begin
      @(negedge CLK);
      rdy = in_ready;
      @(posedge CLK);
      #1;
      if (rdy) break;
      t++;
      if (t > 200) begin
        n_chk++;
        n_fail++;
        $display("FAIL send_timeout: wa %0d still not accepted after %0d cycles", b.wa, t);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic chk_seq(input string nm, input int first, input int n);
    chk({nm, "_count"}, BW'(seen_wa.size()), BW'(n));
    for (int i = 0; i < n && i < seen_wa.size(); i++)
      chk(nm, BW'(seen_wa[i]), BW'(first + i));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(negedge CLK);
    chk("rst_out_valid", BW'(out_valid), '0);
    chk("rst_in_ready", BW'(in_ready), BW'(1));
    chk("rst_outputs", {ALUOutW, ReadDataW, ALUControlW, PCSrcW, RegWriteW, MemtoRegW,
                        WA3W, v_s_w, LaneMaskW}, '0);
    RST_N = 1'b1;
    omode = 0;
    @(posedge CLK); #1;

    // Back-to-back stream of 8 beats
    seen_wa.delete();
    for (int i = 1; i <= 8; i++) send(rand_beat(RAW'(i), 1'b1, 16'hFFFF));
    idle(4);
    chk_seq("stream_wa", 1, 8);

    // Scalar vs vector mask
    send(rand_beat(4'd5, 1'b0, 16'hFFFF));
    send(rand_beat(4'd6, 1'b1, 16'hFFFF));
    idle(4);
    chk("scalar_mask", BW'(mask_by_wa[5]), BW'(16'h0001));
    chk("vector_mask", BW'(mask_by_wa[6]), BW'(16'hFFFF));

    // Stall then release: order preserved
    omode = 2;
    idle(2);
    seen_wa.delete();
    send(rand_beat(4'd1, 1'b1, 16'h00F0));
    if (HAS_SKID) send(rand_beat(4'd2, 1'b1, 16'h0F00));
    @(negedge CLK);
    chk("stall_in_ready", BW'(in_ready), '0);
    @(posedge CLK); #1;
    idle(2);
    omode = 0;
    send(rand_beat(HAS_SKID ? 4'd3 : 4'd2, 1'b1, 16'h1234));
    idle(4);
    chk_seq("stall_wa", 1, HAS_SKID ? 3 : 2);

    // Flush while full (skid occupied when compiled in) with a beat offered
    omode = 2;
    idle(2);
    seen_wa.delete();
    send(rand_beat(4'd11, 1'b1, 16'hFFFF));
    if (HAS_SKID) send(rand_beat(4'd12, 1'b1, 16'hFFFF));
    in_valid = 1'b1; WA3M = 4'd13; RegWriteM = 1'b1; LaneMaskM = 16'hFFFF; v_s_m = 1'b1;
    FLUSH = 1'b1;
    @(posedge CLK); #1;
    FLUSH = 1'b0;
    in_valid = 1'b0;
    @(negedge CLK);
    chk("flush_out_valid", BW'(out_valid), '0);
    chk("flush_regwrite", BW'(RegWriteW), '0);
    chk("flush_lanemask", BW'(LaneMaskW), '0);
    chk("flush_in_ready", BW'(in_ready), BW'(1));
    @(posedge CLK); #1;
    omode = 0;
    for (int i = 1; i <= 3; i++) send(rand_beat(RAW'(i), 1'b1, 16'h00FF));
    idle(4);
    chk_seq("post_flush_wa", 1, 3);

    // Asynchronous reset in the middle of a stall
    omode = 2;
    idle(2);
    send(rand_beat(4'd7, 1'b1, 16'hAAAA));
    if (HAS_SKID) send(rand_beat(4'd8, 1'b1, 16'h5555));
    #3;
    RST_N = 1'b0;
    #1;
    chk("midrst_out_valid", BW'(out_valid), '0);
    chk("midrst_in_ready", BW'(in_ready), BW'(1));
    chk("midrst_outputs", {ALUOutW, ReadDataW, ALUControlW, PCSrcW, RegWriteW, MemtoRegW,
                           WA3W, v_s_w, LaneMaskW}, '0);
    @(negedge CLK);
    RST_N = 1'b1;
    omode = 0;
    seen_wa.delete();
    @(posedge CLK); #1;
    for (int i = 9; i <= 12; i++) send(rand_beat(RAW'(i), 1'b1, 16'hF0F0));
    idle(4);
    chk_seq("post_rst_wa", 9, 4);

    // Randomised traffic with random backpressure and gaps
    omode = 1;
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle(1);
      else send(rand_beat(RAW'($urandom), 1'($urandom), LANES'($urandom)));
    end
    omode = 0;
    idle(5);
    chk("drained", BW'(out_valid), '0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_reg_mw_elastic.md
# pipe_reg_mw_elastic

Parametrised MEM→WB pipeline stage for the vector core, carrying lane results, load data and write-back control from the memory stage to the write-back stage. It replaces the free-running MEM/WB register with an elastic valid/ready stage that adds stall propagation, flush, a per-lane write mask and a full-throughput skid buffer. The stage sits between the data-memory interface and the register-file write port.

## Interface
- LANES, 16, number of vector lanes
- DW, 32, bits per lane
- RAW, 4, register-file address width
- ACW, 3, ALU control width
- CLK  in  1  clock, rising edge
- RST_N  in  1  asynchronous active-low reset
- FLUSH  in  1  synchronous kill of all held and incoming beats
- in_valid  in  1  M-stage beat present
- in_ready  out  1  stage can accept a beat
- ALUOutM, ReadDataM  in  LANES×DW each  ALU result / load data per lane
- ALUControlM  in  ACW  ALU op
- PCSrcM, RegWriteM, MemtoRegM, v_s_m  in  1 each  control flags (v_s: 1=vector, 0=scalar)
- WA3M  in  RAW  destination register
- LaneMaskM  in  LANES  per-lane write enable
- out_valid  out  1  W-stage beat present
- out_ready  in  1  W stage consumes the beat
- ALUOutW, ReadDataW, ALUControlW, PCSrcW, RegWriteW, MemtoRegW, WA3W, v_s_w, LaneMaskW  out  same widths as the M ports

## Operation
- Beat accepted when in_valid && in_ready; beat retired when out_valid && out_ready.
- Storage: main register (drives outputs) plus skid register. States: EMPTY (neither valid), FULL (main valid), SKID (both valid).
- EMPTY: accept → FULL.
- FULL: accept && retire → FULL (main reloaded); accept && !retire → SKID (beat into skid); retire only → EMPTY.
- SKID: in_ready=0; retire → FULL (skid moves to main, skid cleared).
- Order is strictly FIFO; no beat is duplicated or dropped except by FLUSH.
- FLUSH: next state EMPTY regardless of handshakes; any beat accepted in the same cycle is discarded; RegWriteW, PCSrcW, MemtoRegW, LaneMaskW forced to 0 with out_valid. Data buses keep their prior value.
- RegWriteW is meaningful only when out_valid=1; downstream qualifies writes with out_valid && RegWriteW && LaneMaskW[i].
- Scalar beats (v_s=0) pass lane 0 only: LaneMaskW captured as LaneMaskM & 'b1.
- Reset (any time, including mid-transfer): state EMPTY, in_ready=1, out_valid=0, all data/control outputs 0.

## Timing
- Latency in→out: 1 cycle (beat accepted at edge N is visible at outputs after edge N).
- Throughput: 1 beat/cycle while out_ready=1.
- in_ready is a registered output (no combinational path from out_ready) when the skid is compiled in.
- Outputs change only on CLK rising edge or RST_N falling edge.
- After RST_N deasserts, first beat may be accepted on the first CLK edge.

## Configuration
- PIPE_MW_SKID_EN defined: two-entry operation as above; in_ready = !skid_valid (registered).
- Not defined: single entry only (no SKID state); in_ready = !out_valid || out_ready (combinational); same latency, full throughput, but a timing path out_ready→in_ready exists.

## Structure
- Package pipe_pkg: default constants for LANES/DW/RAW/ACW, state enum pipe_st_t {EMPTY, FULL, SKID}, and the packed payload struct mw_payload_t built from those constants.
- One sub-module: pipe_skid_buf, generic over payload width, implementing the state machine and storage; the top packs/unpacks mw_payload_t and applies the flush/scalar-mask rules.

## Test plan
- Reset then stream 8 beats with out_ready=1 (WA3M=1..8) → WA3W=1..8 on consecutive cycles, out_valid continuous, in_ready stays 1.
- Stall: out_ready=0 for 3 cycles during streaming → one beat held in main, one in skid, in_ready=0 next cycle; on release beats emerge in order, none lost.
- FLUSH asserted while in SKID with in_valid=1 → next cycle out_valid=0, RegWriteW=0, LaneMaskW=0, in_ready=1; flushed WA3 values never appear.
- Scalar beat v_s_m=0, LaneMaskM=16'hFFFF → LaneMaskW=16'h0001; vector beat same mask → 16'hFFFF.
- RST_N pulsed low mid-stall (SKID) → outputs immediately 0, out_valid=0, in_ready=1; resumed stream starts clean.
- Build without PIPE_MW_SKID_EN: out_ready=0 with main full → in_ready=0 same cycle; out_ready=1 → in_ready=1 same cycle, back-to-back transfer.
